poly_addsub_seq: RTL and testbench
==================================

// Module: poly_addsub_seq
// PURPOSE
//  Sequencer upstream of the modular add/sub unit: on start, streams all N coefficient pairs of
//  polynomials A and B from two sync-read coefficient RAMs into the unit (op1=A[i], op2=B[i]).
//  It then writes the returned results in order to a result RAM and pulses done.
//  This is the control stage for whole-polynomial add/sub (FIPS 203 poly ops).
// PARAMETERS
//  N          256  coefficients per polynomial (power of 2)
//  RD_LAT     1    RAM read latency in cycles (ren/addr -> rdata)
//  AS_LAT     2    add/sub unit latency (valid_o -> res_valid_i); sizes drain timeout only
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        reset, asynchronous assert, active-low
//  start_i      in   1        start request, honoured only in IDLE
//  is_sub_i     in   1        1 = A-B, 0 = A+B; sampled with start_i
//  busy_o       out  1        high in RUN or DRAIN
//  done_o       out  1        one-cycle pulse, all N results written
//  rd_en_o      out  1        read enable, shared by A and B RAMs
//  rd_addr_o    out  log2(N)  read address, shared
//  a_rdata_i    in   12       A[rd_addr] RD_LAT cycles after rd_en_o
//  b_rdata_i    in   12       B[rd_addr] RD_LAT cycles after rd_en_o
//  op1_o        out  12       to add/sub unit operand 1 (= a_rdata_i, combinational pass)
//  op2_o        out  12       to add/sub unit operand 2 (= b_rdata_i)
//  is_sub_o     out  1        latched operation mode
//  valid_o      out  1        operand-pair valid to add/sub unit
//  res_i        in   12       result from add/sub unit
//  res_valid_i  in   1        result valid from add/sub unit
//  wr_en_o      out  1        result RAM write enable
//  wr_addr_o    out  log2(N)  result RAM write address
//  wr_data_o    out  12       result RAM write data
// BEHAVIOUR
//  - Reset: state IDLE; busy_o, done_o, rd_en_o, valid_o, wr_en_o = 0; rd_addr_o, wr_addr_o,
//    wr_data_o = 0; is_sub_o = 0; rd/wr counters = 0. Async reset mid-operation aborts at once.
//  - FSM IDLE -> RUN on start_i; latch is_sub_i into is_sub_o; clear both counters.
//  - RUN: each cycle assert rd_en_o with rd_addr_o = rd count, then increment.
//    After issuing address N-1 -> DRAIN. rd_addr_o never wraps within one run.
//  - valid_o = rd_en_o delayed RD_LAT cycles through a reset-clearable shift register.
//    op1_o/op2_o carry the RAM data in the same cycle.
//  - Results: every res_valid_i in RUN/DRAIN registers wr_en_o=1, wr_data_o=res_i,
//    wr_addr_o=wr count, then increments (1-cycle registered write path).
//    The add/sub unit has no backpressure; order is preserved.
//  - DRAIN -> DONE when the N-th result is written (wr count reaches N; counter width log2(N)+1).
//  - DONE: done_o = 1 for exactly one cycle, then IDLE. busy_o is low in DONE and IDLE.
//  - start_i outside IDLE is ignored; is_sub_o holds for the whole run.
//    Back-to-back: start_i in the cycle after done_o is accepted.
//  - res_valid_i in IDLE/DONE is ignored (no write, counters unchanged).
//  - Throughput 1 pair/cycle. Run length start->done_o = N + RD_LAT + AS_LAT + 2 cycles.
// CONFIGURATION
//  POLY_ADDSUB_RANGE_CHK_EN defined: adds port err_o (out, 1). err_o is a sticky error flag:
//    it is set when valid_o=1 and either a_rdata_i or b_rdata_i >= Q.
//    err_o clears on accepted start_i and resets to 0. Data flow is unaffected.
//  Not defined: no err_o port, no compare logic; behaviour otherwise identical.
// STRUCTURE
//  poly_arith_pkg: reuse Q, coeff_t; add N_COEFF=256 and poly_idx_t (logic [7:0]).
//  Sub-module poly_valid_delay (parameter DEPTH, async active-low clear) for the rd_en->valid pipe.
//  FSM, counters and write register stay in this module.
// TESTING (bench models RAMs with RD_LAT and the 2-cycle add/sub unit)
//  1 Add: A[i]=i, B[i]=3328, start, is_sub=0 -> wr_data[i]=(i+3328) mod 3329 (i=1 -> 0)
//    -> done_o single pulse at cycle N+RD_LAT+AS_LAT+2.
//  2 Sub: A=0, B[i]=i, is_sub=1 -> result[0]=0, result[i]=3329-i.
//    wr_addr sequence 0..255, no gaps.
//  3 start_i held high through the run with is_sub_i toggled -> one run only,
//    is_sub_o constant, done_o once. Next start after done_o accepted.
//  4 rst_n low at rd_addr=100 -> all outputs 0 asynchronously, IDLE.
//    A new start then produces a full 256-entry run.
//  5 Spurious res_valid_i while IDLE -> wr_en_o stays 0, no counter change.
//  6 (RANGE_CHK_EN) A[7]=3329 -> err_o rises the cycle after valid_o for index 7,
//    stays high through done_o, clears on next start.

Source files
------------

// File: rtl/poly_arith_pkg.sv
// rtl/poly_arith_pkg.sv - shared ML-KEM coefficient types, constants and sequencer state encoding
package poly_arith_pkg;

    localparam int Q       = 3329;
    localparam int N_COEFF = 256;

    typedef logic [11:0] coeff_t;
    typedef logic [7:0]  poly_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    function automatic logic coeff_in_range(input coeff_t c);
        return (c < coeff_t'(Q));
    endfunction

endpackage

// File: rtl/poly_valid_delay.sv
// rtl/poly_valid_delay.sv - clearable shift register aligning read enable with returned RAM data
module poly_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] r_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign dout = r_pipe[DEPTH-1];

endmodule

// File: rtl/poly_addsub_seq.sv
// rtl/poly_addsub_seq.sv - streams coefficient pairs to the mod add/sub unit and writes results back
// Optional range check on RAM data: POLY_ADDSUB_RANGE_CHK_EN
module poly_addsub_seq
    import poly_arith_pkg::*;
#(
    parameter int N      = N_COEFF,
    parameter int RD_LAT = 1,
    parameter int AS_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 is_sub_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 rd_en_o,
    output logic [$clog2(N)-1:0] rd_addr_o,
    input  logic [11:0]          a_rdata_i,
    input  logic [11:0]          b_rdata_i,
    output logic [11:0]          op1_o,
    output logic [11:0]          op2_o,
    output logic                 is_sub_o,
    output logic                 valid_o,
    input  logic [11:0]          res_i,
    input  logic                 res_valid_i,
    output logic                 wr_en_o,
    output logic [$clog2(N)-1:0] wr_addr_o,
    output logic [11:0]          wr_data_o
`ifdef POLY_ADDSUB_RANGE_CHK_EN
    ,
    output logic                 err_o
`endif
);

    localparam int AW        = $clog2(N);
    localparam int CW        = AW + 1;
    // Results are all back RD_LAT+AS_LAT+2 cycles into DRAIN; beyond this the unit is presumed lost.
    localparam int DRAIN_MAX = RD_LAT + AS_LAT + 4;
    localparam int DW        = $clog2(DRAIN_MAX + 1);

    seq_state_t     r_state;
    logic [AW-1:0]  r_rd_cnt;
    logic [CW-1:0]  r_wr_cnt;
    logic [DW-1:0]  r_drain_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_rd_en;
    logic [AW-1:0]  r_rd_addr;
    logic           r_is_sub;
    logic           r_wr_en;
    logic [AW-1:0]  r_wr_addr;
    coeff_t         r_wr_data;
    logic           w_valid;
    logic           w_capture;
    logic           w_start;

    assign w_start   = (r_state == ST_IDLE) && start_i;
    assign w_capture = res_valid_i && ((r_state == ST_RUN) || (r_state == ST_DRAIN));

    poly_valid_delay #(.DEPTH(RD_LAT)) u_valid_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (r_rd_en),
        .dout  (w_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_is_sub    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            if (w_capture) begin
                r_wr_en   <= 1'b1;
                r_wr_data <= res_i;
                r_wr_addr <= r_wr_cnt[AW-1:0];
                r_wr_cnt  <= r_wr_cnt + CW'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    r_rd_en <= 1'b0;
                    if (start_i) begin
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                        r_is_sub <= is_sub_i;
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= r_rd_cnt;
                    if (r_rd_cnt == AW'(N - 1)) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= '0;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    r_rd_en     <= 1'b0;
                    r_drain_cnt <= r_drain_cnt + DW'(1);
                    if (r_wr_cnt == CW'(N)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_drain_cnt == DW'(DRAIN_MAX)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef POLY_ADDSUB_RANGE_CHK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= 1'b0;
        end else if (w_valid && (!coeff_in_range(a_rdata_i) || !coeff_in_range(b_rdata_i))) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign rd_en_o   = r_rd_en;
    assign rd_addr_o = r_rd_addr;
    assign op1_o     = a_rdata_i;
    assign op2_o     = b_rdata_i;
    assign is_sub_o  = r_is_sub;
    assign valid_o   = w_valid;
    assign wr_en_o   = r_wr_en;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;

endmodule

// File: tb/tb_poly_addsub_seq.sv
// tb/tb_poly_addsub_seq.sv - self-checking bench: RAM and add/sub unit models with result scoreboard
module tb_poly_addsub_seq;
    import poly_arith_pkg::*;

    localparam int N      = 256;
    localparam int RD_LAT = 1;
    localparam int AS_LAT = 2;
    localparam int RUN_LEN = N + RD_LAT + AS_LAT + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        is_sub_i;
    logic        busy_o;
    logic        done_o;
    logic        rd_en_o;
    logic [7:0]  rd_addr_o;
    logic [11:0] a_rdata_i = '0;
    logic [11:0] b_rdata_i = '0;
    logic [11:0] op1_o;
    logic [11:0] op2_o;
    logic        is_sub_o;
    logic        valid_o;
    logic [11:0] res_i;
    logic        res_valid_i;
    logic        wr_en_o;
    logic [7:0]  wr_addr_o;
    logic [11:0] wr_data_o;
`ifdef POLY_ADDSUB_RANGE_CHK_EN
    logic        err_o;
`endif

    logic [11:0] mem_a [N];
    logic [11:0] mem_b [N];
    logic        u_v1 = 1'b0, u_v2 = 1'b0;
    logic [11:0] u_r1 = '0, u_r2 = '0;
    logic        inj_v;
    logic [11:0] inj_d;
    int          wq_addr [$];
    int          wq_data [$];
    int          done_cnt;
    int          vectors = 0;
    int          miscompares = 0;

    poly_addsub_seq #(.N(N), .RD_LAT(RD_LAT), .AS_LAT(AS_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .is_sub_i    (is_sub_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .a_rdata_i   (a_rdata_i),
        .b_rdata_i   (b_rdata_i),
        .op1_o       (op1_o),
        .op2_o       (op2_o),
        .is_sub_o    (is_sub_o),
        .valid_o     (valid_o),
        .res_i       (res_i),
        .res_valid_i (res_valid_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o)
`ifdef POLY_ADDSUB_RANGE_CHK_EN
        ,
        .err_o       (err_o)
`endif
    );

    always #5 clk = ~clk;

    // Coefficient RAMs, one-cycle synchronous read
    always @(posedge clk) begin
        if (rd_en_o) begin
            a_rdata_i <= mem_a[rd_addr_o];
            b_rdata_i <= mem_b[rd_addr_o];
        end
    end

    // Two-stage modular add/sub unit
    always @(posedge clk) begin
        u_v1 <= valid_o;
        if (is_sub_o) u_r1 <= 12'((int'(op1_o) + Q - int'(op2_o)) % Q);
        else          u_r1 <= 12'((int'(op1_o) + int'(op2_o)) % Q);
        u_v2 <= u_v1;
        u_r2 <= u_r1;
    end

    assign res_valid_i = u_v2 | inj_v;
    assign res_i       = inj_v ? inj_d : u_r2;

    // Result RAM write log
    always @(posedge clk) begin
        #1;
        if (wr_en_o) begin
            wq_addr.push_back(int'(wr_addr_o));
            wq_data.push_back(int'(wr_data_o));
        end
        if (done_o) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int exp_res(int i, bit s);
        int d;
        d = s ? int'(mem_a[i]) - int'(mem_b[i]) : int'(mem_a[i]) + int'(mem_b[i]);
        return ((d % Q) + Q) % Q;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_random();
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 12'($urandom_range(0, Q - 1));
            mem_b[i] = 12'($urandom_range(0, Q - 1));
        end
    endtask

    task automatic check_results(string tag, bit s);
        chk({tag, " write count"}, wq_addr.size(), N);
        for (int i = 0; i < N && i < wq_addr.size(); i++) begin
            chk({tag, " wr_addr"}, wq_addr[i], i);
            chk({tag, " wr_data"}, wq_data[i], exp_res(i, s));
        end
        chk({tag, " done pulses"}, done_cnt, 1);
    endtask

    task automatic run_and_check(string tag, bit s);
        int cyc;
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        is_sub_i = s;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        chk({tag, " busy after start"}, busy_o, 1);
        cyc = 0;
        while (!done_o && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk({tag, " start-to-done cycles"}, cyc, RUN_LEN);
        tick();
        chk({tag, " done single pulse"}, done_o, 0);
        chk({tag, " busy low after done"}, busy_o, 0);
        check_results(tag, s);
    endtask

    initial begin
        int   cyc;
        int   bad;
        logic [7:0]  sv_addr;
        logic [11:0] sv_data;

        rst_n    = 1'b0;
        start_i  = 1'b0;
        is_sub_i = 1'b0;
        inj_v    = 1'b0;
        inj_d    = '0;
        done_cnt = 0;
        tick();
        tick();
        chk("reset busy",    busy_o, 0);
        chk("reset done",    done_o, 0);
        chk("reset rd_en",   rd_en_o, 0);
        chk("reset valid",   valid_o, 0);
        chk("reset wr_en",   wr_en_o, 0);
        chk("reset rd_addr", rd_addr_o, 0);
        chk("reset wr_addr", wr_addr_o, 0);
        chk("reset wr_data", wr_data_o, 0);
        chk("reset is_sub",  is_sub_o, 0);
        rst_n = 1'b1;
        tick();

        // Add with wrap-around: A[i]=i, B[i]=Q-1
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 12'(i);
            mem_b[i] = 12'(Q - 1);
        end
        run_and_check("add", 1'b0);

        // Subtract, started in the cycle right after done_o
        for (int i = 0; i < N; i++) begin
            mem_a[i] = '0;
            mem_b[i] = 12'(i);
        end
        run_and_check("sub", 1'b1);

        // start_i held high with is_sub_i toggling
        load_random();
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        is_sub_i = 1'b0;
        start_i  = 1'b1;
        tick();
        bad = 0;
        cyc = 0;
        while (!done_o && cyc < 1000) begin
            is_sub_i = ~is_sub_i;
            if (is_sub_o !== 1'b0) bad++;
            tick();
            cyc++;
        end
        chk("held-start is_sub_o changes", bad, 0);
        chk("held-start run length", cyc, RUN_LEN);
        start_i = 1'b0;
        tick();
        tick();
        chk("held-start no second run", busy_o, 0);
        check_results("held-start", 1'b0);

        // Asynchronous reset in the middle of a run
        load_random();
        is_sub_i = 1'b1;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        cyc = 0;
        while (!(rd_en_o && rd_addr_o == 8'd100) && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("abort reached rd_addr 100", rd_addr_o, 100);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy",    busy_o, 0);
        chk("abort done",    done_o, 0);
        chk("abort rd_en",   rd_en_o, 0);
        chk("abort valid",   valid_o, 0);
        chk("abort wr_en",   wr_en_o, 0);
        chk("abort rd_addr", rd_addr_o, 0);
        chk("abort wr_addr", wr_addr_o, 0);
        chk("abort wr_data", wr_data_o, 0);
        chk("abort is_sub",  is_sub_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        load_random();
        run_and_check("post-abort", 1'b0);

        // Spurious results while idle
        sv_addr = wr_addr_o;
        sv_data = wr_data_o;
        inj_d   = 12'd123;
        inj_v   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle res_valid wr_en", wr_en_o, 0);
            chk("idle res_valid wr_addr", wr_addr_o, sv_addr);
            chk("idle res_valid wr_data", wr_data_o, sv_data);
            chk("idle res_valid busy", busy_o, 0);
        end
        inj_v = 1'b0;
        tick();
        load_random();
        run_and_check("post-spurious", 1'b1);

        for (int r = 0; r < 2; r++) begin
            load_random();
            run_and_check("random", 1'($urandom_range(0, 1)));
        end

`ifdef POLY_ADDSUB_RANGE_CHK_EN
        load_random();
        mem_a[7] = 12'(Q);
        is_sub_i = 1'b0;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        cyc = 0;
        while (!(valid_o && op1_o == 12'(Q)) && cyc < 1000) begin
            chk("err low before bad index", err_o, 0);
            tick();
            cyc++;
        end
        chk("err low with bad valid", err_o, 0);
        tick();
        chk("err set after bad valid", err_o, 1);
        cyc = 0;
        while (!done_o && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("err sticky at done", err_o, 1);
        tick();
        mem_a[7] = 12'd5;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        chk("err cleared on start", err_o, 0);
        cyc = 0;
        while (!done_o && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("err stays clear on valid data", err_o, 0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
